// File: rtl/a0_trace_pkg.sv
// Shared types for the a0 trace capture block: FSM states, timestamp width
// and the entry layout (optional timestamp enabled by A0_TRACE_TIMESTAMP_EN).
package a0_trace_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    HALTED = 2'd2
  } trace_state_t;

  localparam int TS_WIDTH = 32;
  localparam int A0_WIDTH = 32;

  // Entry layout at the default a0 width; the top packs {ts, value} the same way.
  typedef struct packed {
`ifdef A0_TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts;
`endif
    logic [A0_WIDTH-1:0] value;
  } trace_entry_t;

endpackage

// File: rtl/a0_trace_fifo_sync_fifo.sv
// First-word-fall-through FIFO with an exact occupancy count; the head entry
// is held in a register so the output is glitch-free and stable while idle.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [W-1:0]  dout_r;

  logic          full_s;
  logic          pop_ok_s;
  logic          push_ok_s;
  logic [AW-1:0] rd_next_s;
  logic [CW-1:0] count_next_s;
  logic [W-1:0]  dout_next_s;

  // Handshake qualification and next-state computation
  always_comb begin
    full_s       = (count_r == CW'(DEPTH));
    pop_ok_s     = pop && (count_r != {CW{1'b0}});
    push_ok_s    = push && (!full_s || pop_ok_s);
    drop         = push && full_s && !pop_ok_s;
    rd_next_s    = pop_ok_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
    count_next_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
    // A push into an (effectively) empty FIFO bypasses storage to the head.
    if (push_ok_s && (count_r == CW'(pop_ok_s))) begin
      dout_next_s = din;
    end else if (pop_ok_s && (count_r > CW'(1))) begin
      dout_next_s = mem_r[rd_next_s];
    end else begin
      dout_next_s = dout_r;
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy and head register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      dout_r   <= {W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r <= rd_next_s;
      count_r  <= count_next_s;
      dout_r   <= dout_next_s;
    end
  end

  assign dout  = dout_r;
  assign count = count_r;

endmodule

// File: rtl/a0_trace_fifo.sv
// Records every change of the CPU a0 register into a FIFO drained by the host.
// Define A0_TRACE_TIMESTAMP_EN to tag each entry with a 32-bit cycle stamp.
module a0_trace_fifo
  import a0_trace_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       a0_in,
  input  logic                   start,
  input  logic                   stop,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
`ifdef A0_TRACE_TIMESTAMP_EN
  output logic [TS_WIDTH-1:0]    out_ts,
`endif
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   armed
);

`ifdef A0_TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = TS_WIDTH + WIDTH;
  logic [TS_WIDTH-1:0] ts_r;
`else
  localparam int ENTRY_W = WIDTH;
`endif

  trace_state_t       state_r;
  logic [WIDTH-1:0]   last_a0_r;
  logic               overflow_r;
  logic               armed_r;
  logic               push_req_s;
  logic               pop_req_s;
  logic               drop_s;
  logic [ENTRY_W-1:0] entry_s;
  logic [ENTRY_W-1:0] head_s;
  logic [$clog2(DEPTH):0] count_s;

  // A change coinciding with stop is deliberately not captured.
  assign push_req_s = (state_r == ARMED) && !stop && (a0_in != last_a0_r);
  assign pop_req_s  = out_valid && out_ready;

`ifdef A0_TRACE_TIMESTAMP_EN
  // Stamp = number of ARMED edges elapsed, including the capturing one.
  assign entry_s = {ts_r + TS_WIDTH'(1), a0_in};
`else
  assign entry_s = a0_in;
`endif

  // Capture FSM with baseline tracking, sticky overflow and cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      armed_r    <= 1'b0;
      last_a0_r  <= {WIDTH{1'b0}};
      overflow_r <= 1'b0;
`ifdef A0_TRACE_TIMESTAMP_EN
      ts_r       <= {TS_WIDTH{1'b0}};
`endif
    end else begin
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      case (state_r)
        IDLE, HALTED: begin
          if (start && !stop) begin
            state_r    <= ARMED;
            armed_r    <= 1'b1;
            last_a0_r  <= a0_in;
            overflow_r <= 1'b0;
`ifdef A0_TRACE_TIMESTAMP_EN
            ts_r       <= {TS_WIDTH{1'b0}};
`endif
          end
        end
        ARMED: begin
          last_a0_r <= a0_in;
`ifdef A0_TRACE_TIMESTAMP_EN
          ts_r      <= ts_r + TS_WIDTH'(1);
`endif
          if (stop) begin
            state_r <= HALTED;
            armed_r <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          armed_r <= 1'b0;
        end
      endcase
    end
  end

  sync_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req_s),
    .pop   (pop_req_s),
    .din   (entry_s),
    .dout  (head_s),
    .count (count_s),
    .drop  (drop_s)
  );

  assign count     = count_s;
  assign out_valid = (count_s != '0);
  assign out_data  = head_s[WIDTH-1:0];
`ifdef A0_TRACE_TIMESTAMP_EN
  assign out_ts    = head_s[ENTRY_W-1:WIDTH];
`endif
  assign overflow  = overflow_r;
  assign armed     = armed_r;

endmodule

// File: tb/tb_a0_trace_fifo.sv
// Directed bench for a0_trace_fifo: stimulus pushes expected entries into a
// scoreboard queue, an independent monitor checks each handshake pop.
module tb_a0_trace_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a0_in;
  logic             start;
  logic             stop;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             armed;
`ifdef A0_TRACE_TIMESTAMP_EN
  logic [31:0]      out_ts;
`endif

  typedef struct {
    logic [31:0] value;
    logic [31:0] ts;
    bit          chk_ts;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pops   = 0;

  a0_trace_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .a0_in     (a0_in),
    .start     (start),
    .stop      (stop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef A0_TRACE_TIMESTAMP_EN
    .out_ts    (out_ts),
`endif
    .count     (count),
    .overflow  (overflow),
    .armed     (armed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_push(input logic [31:0] v, input logic [31:0] ts, input bit use_ts);
    exp_t e;
    e.value  = v;
    e.ts     = ts;
    e.chk_ts = use_ts;
    exp_q.push_back(e);
  endtask

  task automatic set_a0(input logic [31:0] v);
    a0_in = v;
    step();
  endtask

  // Monitor: each accepted pop is compared against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got data %0h, required no entry", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", 64'(out_data), 64'(e.value));
`ifdef A0_TRACE_TIMESTAMP_EN
          if (e.chk_ts) chk("pop_ts", 64'(out_ts), 64'(e.ts));
`endif
        end
      end
    end
  end

  initial begin
    int pops_before;
    rst = 1'b1; a0_in = 32'd0; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_armed", 64'(armed), 64'd0);
    rst = 1'b0;

    // IDLE ignores changes; arming takes a baseline without pushing
    set_a0(32'd1); set_a0(32'd2); set_a0(32'd3);
    chk("idle_count", 64'(count), 64'd0);
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_armed", 64'(armed), 64'd0);
    start = 1'b1; step(); start = 1'b0;
    chk("arm_armed", 64'(armed), 64'd1);
    chk("arm_count", 64'(count), 64'd0);
    step();
    chk("baseline_count", 64'(count), 64'd0);
    expect_push(32'd9, 32'd0, 1'b0); set_a0(32'd9);
    chk("first_push_latency", 64'(count), 64'd1);
    chk("first_push_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("drain1_count", 64'(count), 64'd0);

    // Re-arm with baseline 0, then 5,5,7 and a non-adjacent return to 5
    stop = 1'b1; step(); stop = 1'b0;
    a0_in = 32'd0; start = 1'b1; step(); start = 1'b0;
    expect_push(32'd5, 32'd0, 1'b0); set_a0(32'd5);
    set_a0(32'd5);
    expect_push(32'd7, 32'd0, 1'b0); set_a0(32'd7);
    chk("dup_count", 64'(count), 64'd2);
    chk("dup_head", 64'(out_data), 64'd5);
    out_ready = 1'b1; step();
    chk("after_pop_head", 64'(out_data), 64'd7);
    step(); out_ready = 1'b0;
    expect_push(32'd5, 32'd0, 1'b0); set_a0(32'd5);
    chk("return_count", 64'(count), 64'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Overflow: five changes into a four-deep FIFO
    for (int i = 1; i <= 4; i++) begin
      expect_push(32'(i), 32'd0, 1'b0);
      set_a0(32'(i));
    end
    set_a0(32'd6);
    chk("ovf_count", 64'(count), 64'd4);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_head", 64'(out_data), 64'd1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("halt_armed", 64'(armed), 64'd0);
    start = 1'b1; step(); start = 1'b0;
    chk("rearm_clears_ovf", 64'(overflow), 64'd0);
    chk("rearm_keeps_count", 64'(count), 64'd4);

    // Full FIFO: pop and push on the same edge
    out_ready = 1'b1;
    expect_push(32'd8, 32'd0, 1'b0); set_a0(32'd8);
    chk("fullpp_count", 64'(count), 64'd4);
    chk("fullpp_ovf", 64'(overflow), 64'd0);
    repeat (4) step();
    out_ready = 1'b0;
    chk("drain2_count", 64'(count), 64'd0);

    // Stop mid-stream: the change on the stop edge and later ones are ignored
    expect_push(32'd10, 32'd0, 1'b0); set_a0(32'd10);
    expect_push(32'd11, 32'd0, 1'b0); set_a0(32'd11);
    stop = 1'b1; set_a0(32'd12); stop = 1'b0;
    set_a0(32'd13); set_a0(32'd14);
    chk("halted_count", 64'(count), 64'd2);
    chk("halted_armed", 64'(armed), 64'd0);
    pops_before = n_pops;
    out_ready = 1'b1; repeat (3) step(); out_ready = 1'b0;
    chk("halted_drain_pops", 64'(n_pops - pops_before), 64'd2);
    chk("halted_drain_count", 64'(count), 64'd0);
    start = 1'b1; step(); start = 1'b0;
    expect_push(32'd15, 32'd0, 1'b0); set_a0(32'd15);
    chk("resume_count", 64'(count), 64'd1);

    // Asynchronous reset in the middle of a drain
    expect_push(32'd16, 32'd0, 1'b0); set_a0(32'd16);
    expect_push(32'd17, 32'd0, 1'b0); set_a0(32'd17);
    expect_push(32'd18, 32'd0, 1'b0); set_a0(32'd18);
    out_ready = 1'b1; step();
    chk("pre_rst_count", 64'(count), 64'd3);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    step(); rst = 1'b0;
    chk("post_rst_ovf", 64'(overflow), 64'd0);
    chk("post_rst_armed", 64'(armed), 64'd0);

    // Changes three and ten edges after arming
    a0_in = 32'd20; start = 1'b1; step(); start = 1'b0;
    step(); step();
    expect_push(32'd21, 32'd3, 1'b1); set_a0(32'd21);
    repeat (6) step();
    expect_push(32'd22, 32'd10, 1'b1); set_a0(32'd22);
    chk("ts_count", 64'(count), 64'd2);
    out_ready = 1'b1; repeat (2) step(); out_ready = 1'b0;
    step();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("final_count", 64'(count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/a0_trace_fifo.md
Name: a0_trace_fifo

Overview:
- Downstream consumer of the CPU's a0 output: watches a0 every cycle and records each change of value into a FIFO.
- Host side (testbench or display driver) drains the FIFO through a valid/ready handshake.
- Used to log program results (e.g. counter and sine outputs) without missing fast-changing values.
- Start/stop control lets the host window the capture.

Parameters:
- WIDTH, 32, data width of a0 and of each FIFO entry value.
- DEPTH, 16, FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- a0_in  in  WIDTH  a0 value from the CPU register file.
- start  in  1  single-cycle pulse: arm capture.
- stop  in  1  single-cycle pulse: halt capture.
- out_valid  out  1  FIFO head entry available.
- out_ready  in  1  host accepts the head entry.
- out_data  out  WIDTH  head entry value.
- count  out  $clog2(DEPTH)+1  number of entries currently held.
- overflow  out  1  sticky flag: a change was dropped because the FIFO was full.
- armed  out  1  high while in state ARMED.

Behaviour:
- Reset (async, rst=1), effective immediately:
  - state=IDLE; wr/rd pointers=0; count=0; out_valid=0; out_data=0; overflow=0; armed=0; last_a0=0.
- FSM states: IDLE, ARMED, HALTED.
  - IDLE: start -> ARMED.
  - ARMED: stop -> HALTED.
  - HALTED: start -> ARMED.
  - start and stop in the same cycle: stop wins; state unchanged in IDLE.
  - On entry to ARMED: last_a0 <= a0_in (baseline, no push); overflow cleared.
- Capture in ARMED, not on the entry edge:
  - Every edge: last_a0 <= a0_in.
  - If a0_in != last_a0, a push is requested.
  - Equal consecutive values are never pushed.
  - Values that return to an earlier non-adjacent value are pushed.
- Push/pop rules:
  - Push is accepted if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle.
  - A push refused when full is dropped and sets overflow=1. The FIFO contents are unchanged.
  - Pop occurs when out_valid && out_ready.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers:
  - $clog2(DEPTH) bits; wrap modulo DEPTH.
  - count = number of entries held; no pointer-based full/empty ambiguity.
- Output:
  - First-word-fall-through: out_valid = (count!=0); out_data = mem[rd_ptr].
  - Latency: a change sampled at edge k appears on out_data/out_valid after edge k (1 cycle) when the FIFO was empty.
  - out_data holds its value while out_valid && !out_ready.
  - When out_valid=0, out_data is don't-care but stable.
- HALTED: no pushes; draining continues; contents are retained.
- Stop mid-stream: a change occurring on the same edge as stop is not pushed.
- Reset mid-operation: all entries are discarded and overflow is cleared.

Optional Feature:
- Macro: A0_TRACE_TIMESTAMP_EN.
- Defined:
  - A 32-bit cycle counter is reset to 0 on entry to ARMED and increments every cycle while ARMED. It wraps at 2^32 and holds in IDLE/HALTED.
  - Each entry stores {timestamp, value}.
  - Extra port out_ts (out, 32) presents the timestamp of the head entry; it resets to 0.
- Undefined: no counter, no out_ts port, entries are WIDTH bits only.

Decomposition:
- Package a0_trace_pkg holds:
  - typedef enum logic [1:0] trace_state_t {IDLE, ARMED, HALTED};
  - TS_WIDTH=32;
  - entry struct typedef (value plus optional ts).
- One sub-module: sync_fifo, a parameterised FWFT storage with push/pop/count.
- The top level holds the FSM, change detection, overflow and timestamp.

Test Plan:
- Reset, start, then a0_in 0 -> 5 -> 5 -> 7 with out_ready=0 -> count=2; out_data=5; after a pop, out_data=7.
- IDLE with a0_in toggling 1,2,3 -> count stays 0 and out_valid=0. After start, baseline = current value and there is no push.
- DEPTH=4: push 5 distinct values with out_ready=0 -> count=4, overflow=1, FIFO holds the first 4. A subsequent start clears overflow.
- Full FIFO, out_ready=1 on the same cycle as a new change -> pop and push both occur, count stays 4, no overflow.
- stop after 2 pushes, then a0_in changes -> no further pushes; drain yields exactly 2 entries; start again resumes capture.
- Assert rst mid-drain with count=3 -> out_valid=0 and count=0 immediately, without waiting for a clock edge. With A0_TRACE_TIMESTAMP_EN: changes at cycles 3 and 10 after start give out_ts=3, then 10.
